// File: rtl/vslide_seq_if.sv
// Bus interfaces of the vector slide issue sequencer.
//   vslide_cmd_if : command handshake plus busy/done status.
//                   master = command issuer, slave = sequencer.
//   vslide_rd_if  : VRF read request/response port.
//                   master = sequencer, slave = VRF.
//   vslide_out_if : chunk stream to the slide datapath (no backpressure).
//                   master = sequencer, slave = slide datapath.

interface vslide_cmd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int VL_WIDTH   = 11,
    parameter int SEW_WIDTH  = 2,
    parameter int DATA_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_vs2_addr;
    logic [ADDR_WIDTH-1:0] cmd_vd_addr;
    logic [VL_WIDTH-1:0]   cmd_vl;
    logic [SEW_WIDTH-1:0]  cmd_sew;
    logic                  cmd_opSel;
    logic                  cmd_insert;
    logic [DATA_WIDTH-1:0] cmd_scalar;
    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_vs2_addr, cmd_vd_addr, cmd_vl, cmd_sew,
               cmd_opSel, cmd_insert, cmd_scalar,
        input  cmd_ready, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_vs2_addr, cmd_vd_addr, cmd_vl, cmd_sew,
               cmd_opSel, cmd_insert, cmd_scalar,
        output cmd_ready, busy, done
    );
endinterface

interface vslide_rd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  rd_req_valid;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic                  rd_req_ready;
    logic                  rd_resp_valid;
    logic [DATA_WIDTH-1:0] rd_resp_data;

    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready, rd_resp_valid, rd_resp_data
    );
    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready, rd_resp_valid, rd_resp_data
    );
endinterface

interface vslide_out_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int SEW_WIDTH  = 2,
    parameter int BE_WIDTH   = 8
);
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_vec0;
    logic [DATA_WIDTH-1:0] out_vec1;
    logic [SEW_WIDTH-1:0]  out_sew;
    logic                  out_start;
    logic                  out_end;
    logic                  out_opSel;
    logic                  out_insert;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [BE_WIDTH-1:0]   out_be;

    modport master (
        output out_valid, out_vec0, out_vec1, out_sew, out_start, out_end,
               out_opSel, out_insert, out_addr, out_be
    );
    modport slave (
        input  out_valid, out_vec0, out_vec1, out_sew, out_start, out_end,
               out_opSel, out_insert, out_addr, out_be
    );
endinterface

// File: rtl/vslide_seq.sv
// Issue-side sequencer for the vector slide unit.
// Accepts one slide command, reads the source register group chunk by chunk
// from the VRF and forwards each returned chunk, one cycle after the response,
// with start/end/byte-enable/destination-address qualifiers.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   cmd      : command handshake + busy/done status (slave side)
//   rd       : VRF read request/response port (master side)
//   out      : chunk stream to the slide datapath (master side, no backpressure)

module vslide_seq #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int VL_WIDTH        = 11,
    parameter int SEW_WIDTH       = 2,
    parameter int BE_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         rst,
    vslide_cmd_if.slave  cmd,
    vslide_rd_if.master  rd,
    vslide_out_if.master out
);

    // Byte count needs 3 extra bits (vl << 3 at SEW 64); the chunk count fits in VL_WIDTH.
    localparam int CNT_W  = VL_WIDTH;
    localparam int NB_W   = VL_WIDTH + 3;
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int OCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic             first;
        logic             last;
        logic [CNT_W-1:0] idx;
    } meta_t;

    function automatic logic [DATA_WIDTH-1:0] replicate(
        input logic [DATA_WIDTH-1:0] s,
        input logic [SEW_WIDTH-1:0]  sew
    );
        case (sew)
            2'd0:    return {8{s[7:0]}};
            2'd1:    return {4{s[15:0]}};
            2'd2:    return {2{s[31:0]}};
            default: return s;
        endcase
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] vs2_q, vs2_d;
    logic [ADDR_WIDTH-1:0] vd_q, vd_d;
    logic [SEW_WIDTH-1:0]  sew_q, sew_d;
    logic                  opsel_q, opsel_d;
    logic                  insert_q, insert_d;
    logic [DATA_WIDTH-1:0] vec1_q, vec1_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [2:0]            tail_q, tail_d;
    logic [CNT_W-1:0]      issue_idx_q, issue_idx_d;
    logic [OCNT_W-1:0]     outst_q, outst_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] ovec0_q, ovec0_d;
    logic [DATA_WIDTH-1:0] ovec1_q, ovec1_d;
    logic [SEW_WIDTH-1:0]  osew_q, osew_d;
    logic                  ostart_q, ostart_d;
    logic                  oend_q, oend_d;
    logic                  oopsel_q, oopsel_d;
    logic                  oinsert_q, oinsert_d;
    logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
    logic [BE_WIDTH-1:0]   obe_q, obe_d;

    meta_t meta_mem [MAX_OUTSTANDING];
    meta_t head;

    logic [NB_W-1:0]  nbytes;
    logic [NB_W-1:0]  nb_round;
    logic [CNT_W-1:0] nchunks;
    logic             accept;
    logic             req_fire;
    logic             pop;

    assign nbytes   = NB_W'(cmd.cmd_vl) << cmd.cmd_sew;
    assign nb_round = nbytes + NB_W'(7);
    assign nchunks  = CNT_W'(nb_round >> 3);

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign cmd.busy      = (state_q != S_IDLE);
    assign cmd.done      = (state_q == S_DONE);
    assign accept        = cmd.cmd_valid && (state_q == S_IDLE);

    assign rd.rd_req_valid = (state_q == S_ISSUE) && (outst_q < OCNT_W'(MAX_OUTSTANDING));
    assign rd.rd_req_addr  = vs2_q + ADDR_WIDTH'(issue_idx_q);
    assign req_fire        = rd.rd_req_valid && rd.rd_req_ready;

    // Responses with nothing outstanding (protocol error, or stale data after a
    // reset) must not pop the FIFO or produce a beat.
    assign pop  = rd.rd_resp_valid && (outst_q != '0) && (state_q != S_IDLE);
    assign head = meta_mem[rd_ptr_q];

    // NOTE: every variable gets its default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        vs2_d       = vs2_q;
        vd_d        = vd_q;
        sew_d       = sew_q;
        opsel_d     = opsel_q;
        insert_d    = insert_q;
        vec1_d      = vec1_q;
        n_d         = n_q;
        tail_d      = tail_q;
        issue_idx_d = issue_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        outst_d     = outst_q;

        // Output stage: every qualifier is zero on cycles without a beat.
        ov_d      = pop;
        ovec0_d   = pop ? rd.rd_resp_data : '0;
        ovec1_d   = pop ? vec1_q : '0;
        osew_d    = pop ? sew_q : '0;
        ostart_d  = pop && head.first;
        oend_d    = pop && head.last;
        oopsel_d  = pop && opsel_q;
        oinsert_d = pop && insert_q;
        oaddr_d   = pop ? (vd_q + ADDR_WIDTH'(head.idx)) : '0;
        obe_d     = '0;
        if (pop) begin
            obe_d = (head.last && (tail_q != 3'd0)) ? ~({BE_WIDTH{1'b1}} << tail_q)
                                                    : {BE_WIDTH{1'b1}};
        end

        if (req_fire) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            issue_idx_d = issue_idx_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Request and response in the same cycle cancel out.
        case ({req_fire, pop})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vs2_d       = cmd.cmd_vs2_addr;
                    vd_d        = cmd.cmd_vd_addr;
                    sew_d       = cmd.cmd_sew;
                    opsel_d     = cmd.cmd_opSel;
                    insert_d    = cmd.cmd_insert;
                    vec1_d      = cmd.cmd_insert ? replicate(cmd.cmd_scalar, cmd.cmd_sew) : '0;
                    n_d         = nchunks;
                    tail_d      = nbytes[2:0];
                    issue_idx_d = '0;
                    state_d     = (cmd.cmd_vl == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_fire && (issue_idx_q == n_q - CNT_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Completion is the cycle the last beat is on the output.
                if (ov_q && oend_q) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vs2_q       <= '0;
            vd_q        <= '0;
            sew_q       <= '0;
            opsel_q     <= 1'b0;
            insert_q    <= 1'b0;
            vec1_q      <= '0;
            n_q         <= '0;
            tail_q      <= '0;
            issue_idx_q <= '0;
            outst_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ov_q        <= 1'b0;
            ovec0_q     <= '0;
            ovec1_q     <= '0;
            osew_q      <= '0;
            ostart_q    <= 1'b0;
            oend_q      <= 1'b0;
            oopsel_q    <= 1'b0;
            oinsert_q   <= 1'b0;
            oaddr_q     <= '0;
            obe_q       <= '0;
        end else begin
            state_q     <= state_d;
            vs2_q       <= vs2_d;
            vd_q        <= vd_d;
            sew_q       <= sew_d;
            opsel_q     <= opsel_d;
            insert_q    <= insert_d;
            vec1_q      <= vec1_d;
            n_q         <= n_d;
            tail_q      <= tail_d;
            issue_idx_q <= issue_idx_d;
            outst_q     <= outst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ov_q        <= ov_d;
            ovec0_q     <= ovec0_d;
            ovec1_q     <= ovec1_d;
            osew_q      <= osew_d;
            ostart_q    <= ostart_d;
            oend_q      <= oend_d;
            oopsel_q    <= oopsel_d;
            oinsert_q   <= oinsert_d;
            oaddr_q     <= oaddr_d;
            obe_q       <= obe_d;
        end
    end

    // NOTE: the metadata storage is not reset; clearing the pointers and the
    // outstanding count makes any stale entry unreachable.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            meta_mem[wr_ptr_q] <= '{first: (issue_idx_q == '0),
                                    last:  (issue_idx_q == n_q - CNT_W'(1)),
                                    idx:   issue_idx_q};
        end
    end

    assign out.out_valid  = ov_q;
    assign out.out_vec0   = ovec0_q;
    assign out.out_vec1   = ovec1_q;
    assign out.out_sew    = osew_q;
    assign out.out_start  = ostart_q;
    assign out.out_end    = oend_q;
    assign out.out_opSel  = oopsel_q;
    assign out.out_insert = oinsert_q;
    assign out.out_addr   = oaddr_q;
    assign out.out_be     = obe_q;

endmodule

// File: tb/tb_vslide_seq.sv
// Self-checking bench for vslide_seq: directed commands, a VRF model with
// configurable in-order response latency, and a scoreboard of expected beats
// and read addresses checked by independent monitor processes.

module tb_vslide_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vslide_cmd_if cmd_if ();
    vslide_rd_if  rd_if  ();
    vslide_out_if out_if ();

    vslide_seq dut (
        .clk (clk),
        .rst (rst),
        .cmd (cmd_if),
        .rd  (rd_if),
        .out (out_if)
    );

    typedef struct packed {
        logic [63:0] vec0;
        logic [63:0] vec1;
        logic [1:0]  sew;
        logic        start;
        logic        fin;
        logic        opsel;
        logic        insert;
        logic [31:0] addr;
        logic [7:0]  be;
    } beat_t;

    typedef struct packed {
        logic [63:0] data;
        int          due;
    } pend_t;

    beat_t       exp_q [$];
    logic [31:0] req_q [$];
    pend_t       pend_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 2;
    int max_pend = 0;
    int req_total = 0;
    int beats_seen = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    bit ready_mode = 1'b0;
    bit stray = 1'b0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic push_beat(input logic [31:0] src, input logic [31:0] dst,
                             input logic [63:0] v1, input logic [1:0] sew,
                             input logic st, input logic en, input logic op,
                             input logic ins, input logic [7:0] be);
        beat_t b;
        b.vec0 = data_of(src); b.vec1 = v1; b.sew = sew; b.start = st; b.fin = en;
        b.opsel = op; b.insert = ins; b.addr = dst; b.be = be;
        exp_q.push_back(b);
        req_q.push_back(src);
    endtask

    // VRF model: decides at the falling edge what the next rising edge sees.
    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
            rd_if.rd_req_ready  = 1'b0;
            rd_if.rd_resp_valid = 1'b0;
            rd_if.rd_resp_data  = '0;
        end else begin
            rd_if.rd_req_ready = ready_mode ? ((cyc % 3) != 1) : 1'b1;
            if (rd_if.rd_req_valid && rd_if.rd_req_ready) begin
                req_total++;
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected read request: got addr %h expected none", rd_if.rd_req_addr);
                end else begin
                    check("rd_req_addr", rd_if.rd_req_addr, req_q.pop_front());
                end
                pend_q.push_back('{data: data_of(rd_if.rd_req_addr), due: cyc + 1 + lat});
                if (pend_q.size() > max_pend) max_pend = pend_q.size();
            end
            if (pend_q.size() != 0 && pend_q[0].due <= cyc + 1) begin
                rd_if.rd_resp_valid = 1'b1;
                rd_if.rd_resp_data  = pend_q[0].data;
                void'(pend_q.pop_front());
            end else if (stray) begin
                rd_if.rd_resp_valid = 1'b1;
                rd_if.rd_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                rd_if.rd_resp_valid = 1'b0;
                rd_if.rd_resp_data  = '0;
            end
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_if.out_valid) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected beat: got addr %h expected none", out_if.out_addr);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat vec0",   out_if.out_vec0,   e.vec0);
                    check("beat vec1",   out_if.out_vec1,   e.vec1);
                    check("beat sew",    out_if.out_sew,    e.sew);
                    check("beat start",  out_if.out_start,  e.start);
                    check("beat end",    out_if.out_end,    e.fin);
                    check("beat opSel",  out_if.out_opSel,  e.opsel);
                    check("beat insert", out_if.out_insert, e.insert);
                    check("beat addr",   out_if.out_addr,   e.addr);
                    check("beat be",     out_if.out_be,     e.be);
                end
            end else begin
                check("idle outputs zero",
                      64'(|{out_if.out_vec0, out_if.out_vec1, out_if.out_sew, out_if.out_start,
                            out_if.out_end, out_if.out_opSel, out_if.out_insert,
                            out_if.out_addr, out_if.out_be}), 64'd0);
            end
            if (cmd_if.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_cmd(input logic [31:0] vs2, input logic [31:0] vd,
                            input logic [10:0] vl, input logic [1:0] sew,
                            input logic opsel, input logic ins, input logic [63:0] scalar);
        @(negedge clk);
        #1;
        check("cmd_ready before accept", cmd_if.cmd_ready, 1'b1);
        cmd_if.cmd_vs2_addr = vs2;
        cmd_if.cmd_vd_addr  = vd;
        cmd_if.cmd_vl       = vl;
        cmd_if.cmd_sew      = sew;
        cmd_if.cmd_opSel    = opsel;
        cmd_if.cmd_insert   = ins;
        cmd_if.cmd_scalar   = scalar;
        cmd_if.cmd_valid    = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 3000 && done_cnt == prev; i++) begin
            @(negedge clk);
            #1;
        end
        check("done pulse seen", done_cnt, prev + 1);
        repeat (3) @(negedge clk);
        #1;
        check("done pulsed once", done_cnt, prev + 1);
        check("all beats emitted", exp_q.size(), 0);
        check("all reads issued", req_q.size(), 0);
        check("busy after command", cmd_if.busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int r0;
        int b0;
        int t;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_vs2_addr = '0; cmd_if.cmd_vd_addr = '0;
        cmd_if.cmd_vl = '0; cmd_if.cmd_sew = '0; cmd_if.cmd_opSel = 1'b0;
        cmd_if.cmd_insert = 1'b0; cmd_if.cmd_scalar = '0;
        rd_if.rd_req_ready = 1'b0; rd_if.rd_resp_valid = 1'b0; rd_if.rd_resp_data = '0;

        // Reset state with all inputs 0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset cmd_ready", cmd_if.cmd_ready, 1'b1);
        check("reset busy", cmd_if.busy, 1'b0);
        check("reset done", cmd_if.done, 1'b0);
        check("reset rd_req_valid", rd_if.rd_req_valid, 1'b0);
        check("reset out_valid", out_if.out_valid, 1'b0);
        mon_en = 1'b1;
        rst = 1'b0;

        // vl=3, SEW32: 12 bytes -> 2 chunks, tail 4.
        lat = 2;
        push_beat(32'h10, 32'h20, 64'h0, 2'd2, 1, 0, 0, 0, 8'hFF);
        push_beat(32'h11, 32'h21, 64'h0, 2'd2, 0, 1, 0, 0, 8'h0F);
        d0 = done_cnt;
        send_cmd(32'h10, 32'h20, 11'd3, 2'd2, 1'b0, 1'b0, 64'h0);
        wait_done(d0);

        // vl=5, SEW8, slide1down: one partial chunk.
        push_beat(32'h30, 32'h40, 64'hABAB_ABAB_ABAB_ABAB, 2'd0, 1, 1, 1, 1, 8'h1F);
        d0 = done_cnt;
        send_cmd(32'h30, 32'h40, 11'd5, 2'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFAB);
        wait_done(d0);

        // vl=16, SEW64, long latency: outstanding reads cap at 4.
        lat = 10;
        max_pend = 0;
        for (int i = 0; i < 16; i++)
            push_beat(32'h200 + i, 32'h100 + i, 64'h0, 2'd3, i == 0, i == 15, 0, 0, 8'hFF);
        d0 = done_cnt;
        send_cmd(32'h200, 32'h100, 11'd16, 2'd3, 1'b0, 1'b0, 64'h0);
        wait_done(d0);
        check("max outstanding reads", max_pend, 4);

        // vl=7, SEW16, slide1up, stalling VRF, address wrap: 14 bytes, tail 6.
        lat = 1;
        ready_mode = 1'b1;
        push_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hCDEF_CDEF_CDEF_CDEF, 2'd1, 1, 0, 0, 1, 8'hFF);
        push_beat(32'h0000_0000, 32'h0000_0000, 64'hCDEF_CDEF_CDEF_CDEF, 2'd1, 0, 1, 0, 1, 8'h3F);
        d0 = done_cnt;
        send_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 11'd7, 2'd1, 1'b0, 1'b1, 64'h1234_5678_9ABC_CDEF);
        wait_done(d0);
        ready_mode = 1'b0;

        // vl=0: no reads, no beats, done right after the accepting edge.
        d0 = done_cnt; r0 = req_total; b0 = beats_seen;
        send_cmd(32'h70, 32'h80, 11'd0, 2'd3, 1'b0, 1'b0, 64'h0);
        wait_done(d0);
        check("vl0 done cycle offset", done_cyc - acc_cyc, 0);
        check("vl0 read count", req_total - r0, 0);
        check("vl0 beat count", beats_seen - b0, 0);

        // Stray response while idle must not produce a beat.
        b0 = beats_seen;
        @(negedge clk);
        #1 stray = 1'b1;
        @(negedge clk);
        #2 stray = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stray response ignored", beats_seen - b0, 0);

        // Reset after the 2nd of 8 beats, then a fresh command.
        lat = 2;
        for (int i = 0; i < 8; i++)
            push_beat(32'h40 + i, 32'h80 + i, 64'h0, 2'd3, i == 0, i == 7, 0, 0, 8'hFF);
        b0 = beats_seen;
        send_cmd(32'h40, 32'h80, 11'd8, 2'd3, 1'b0, 1'b0, 64'h0);
        t = 0;
        while (beats_seen < b0 + 2 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("beats before reset", beats_seen - b0, 2);
        rst = 1'b1;
        exp_q.delete();
        req_q.delete();
        @(negedge clk);
        #1;
        check("mid reset out_valid", out_if.out_valid, 1'b0);
        check("mid reset cmd_ready", cmd_if.cmd_ready, 1'b1);
        check("mid reset busy", cmd_if.busy, 1'b0);
        check("mid reset rd_req_valid", rd_if.rd_req_valid, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        push_beat(32'h50, 32'h60, 64'h0, 2'd3, 1, 0, 0, 0, 8'hFF);
        push_beat(32'h51, 32'h61, 64'h0, 2'd3, 0, 1, 0, 0, 8'hFF);
        d0 = done_cnt;
        send_cmd(32'h50, 32'h60, 11'd2, 2'd3, 1'b0, 1'b0, 64'h0);
        wait_done(d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
